// File: rtl/async_fifo.sv
// Single-clock FIFO with binary pointers mirrored in Gray code, flags registered from next-state pointers.
// Optional overflow/underflow pulse outputs (wOvf, rUdf) enabled by defining ASYNC_FIFO_ERR_EN.
module async_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wData,
    output logic                  wFull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  rEmpty
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic                  wOvf,
    output logic                  rUdf
`endif
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wbin_q,  wbin_d;
    logic [PW-1:0]         wgray_q, wgray_d;
    logic [PW-1:0]         rbin_q,  rbin_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic                  wfull_q, wfull_d;
    logic                  rempty_q, rempty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  w_acc, r_acc;

    // Next-state pointers, flags and read data
    always_comb begin
        w_acc    = winc & ~wfull_q;
        r_acc    = rinc & ~rempty_q;
        wbin_d   = wbin_q + PW'(w_acc);
        rbin_d   = rbin_q + PW'(r_acc);
        wgray_d  = w_acc ? bin2gray(wbin_d) : wgray_q;
        rgray_d  = r_acc ? bin2gray(rbin_d) : rgray_q;
        rempty_d = (rgray_d == wgray_d);
        // Full when Gray pointers differ only in the top two bits
        wfull_d  = (wgray_d == {~rgray_d[ADDR_WIDTH:ADDR_WIDTH-1], rgray_d[ADDR_WIDTH-2:0]});
        rdata_d  = r_acc ? mem[rbin_q[ADDR_WIDTH-1:0]] : rdata_q;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rbin_q   <= '0;
            rgray_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            rdata_q  <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is never cleared; writes are blocked while reset is held
    always_ff @(posedge wclk) begin
        if (w_acc && !wrst) begin
            mem[wbin_q[ADDR_WIDTH-1:0]] <= wData;
        end
    end

    assign wFull  = wfull_q;
    assign rEmpty = rempty_q;
    assign rData  = rdata_q;

`ifdef ASYNC_FIFO_ERR_EN
    logic wovf_q, wovf_d;
    logic rudf_q, rudf_d;

    always_comb begin
        wovf_d = winc & wfull_q;
        rudf_d = rinc & rempty_q;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf_q <= 1'b0;
            rudf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
            rudf_q <= rudf_d;
        end
    end

    assign wOvf = wovf_q;
    assign rUdf = rudf_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo; covers ASYNC_FIFO_ERR_EN outputs when that macro is defined.
module tb_async_fifo;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [7:0] wData;
    logic       wFull;
    logic       rinc;
    logic [7:0] rData;
    logic       rEmpty;
`ifdef ASYNC_FIFO_ERR_EN
    logic       wOvf;
    logic       rUdf;
`endif

    int checks;
    int failures;

    async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .wclk  (wclk),
        .wrst  (wrst),
        .winc  (winc),
        .wData (wData),
        .wFull (wFull),
        .rinc  (rinc),
        .rData (rData),
        .rEmpty(rEmpty)
`ifdef ASYNC_FIFO_ERR_EN
        ,
        .wOvf  (wOvf),
        .rUdf  (rUdf)
`endif
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic test_reset();
        wrst = 1'b1; winc = 1'b0; rinc = 1'b0; wData = 8'h00;
        #1;
        checks++;
        if (rEmpty !== 1'b1 || wFull !== 1'b0 || rData !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold: rEmpty=%b wFull=%b rData=%h, need 1 0 00", rEmpty, wFull, rData);
        end
        #9 wrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge wclk); #1;
            checks++;
            if (rEmpty !== 1'b1 || wFull !== 1'b0 || rData !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle[%0d]: rEmpty=%b wFull=%b rData=%h, need 1 0 00", i, rEmpty, wFull, rData);
            end
`ifdef ASYNC_FIFO_ERR_EN
            checks++;
            if (wOvf !== 1'b0 || rUdf !== 1'b0) begin
                failures++;
                $display("FAIL reset_err[%0d]: wOvf=%b rUdf=%b, need 0 0", i, wOvf, rUdf);
            end
`endif
        end
    endtask

    task automatic fill16(input logic [7:0] base);
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wData = base + 8'(i);
            @(posedge wclk); #1;
            checks++;
            if (wFull !== (i == 15) || rEmpty !== 1'b0) begin
                failures++;
                $display("FAIL fill[%0d]: wFull=%b rEmpty=%b, need %b 0", i, wFull, rEmpty, (i == 15));
            end
        end
        winc = 1'b0;
    endtask

    task automatic drain(input logic [7:0] base, input int n);
        rinc = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge wclk); #1;
            checks++;
            if (rData !== base + 8'(i) || rEmpty !== (i == n - 1) || wFull !== 1'b0) begin
                failures++;
                $display("FAIL drain[%0d]: rData=%h rEmpty=%b wFull=%b, need %h %b 0",
                         i, rData, rEmpty, wFull, base + 8'(i), (i == n - 1));
            end
        end
        rinc = 1'b0;
    endtask

    task automatic test_fill_drain();
        fill16(8'h00);
        drain(8'h00, 16);
    endtask

    task automatic test_overflow();
        fill16(8'h00);
        winc = 1'b1; wData = 8'hAA;
        @(posedge wclk); #1;
        winc = 1'b0;
        checks++;
        if (wFull !== 1'b1 || rEmpty !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flags: wFull=%b rEmpty=%b, need 1 0", wFull, rEmpty);
        end
`ifdef ASYNC_FIFO_ERR_EN
        checks++;
        if (wOvf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pulse: wOvf=%b, need 1", wOvf);
        end
        @(posedge wclk); #1;
        checks++;
        if (wOvf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: wOvf=%b, need 0", wOvf);
        end
`endif
        drain(8'h00, 16);
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        @(posedge wclk); #1;
        rinc = 1'b0;
        checks++;
        if (rData !== 8'h0F || rEmpty !== 1'b1 || wFull !== 1'b0) begin
            failures++;
            $display("FAIL underflow: rData=%h rEmpty=%b wFull=%b, need 0f 1 0", rData, rEmpty, wFull);
        end
`ifdef ASYNC_FIFO_ERR_EN
        checks++;
        if (rUdf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_pulse: rUdf=%b, need 1", rUdf);
        end
        @(posedge wclk); #1;
        checks++;
        if (rUdf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: rUdf=%b, need 0", rUdf);
        end
`endif
    endtask

    task automatic test_stream_wrap();
        winc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wData = 8'(i);
            @(posedge wclk); #1;
        end
        rinc = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wData = 8'(c + 4);
            @(posedge wclk); #1;
            checks++;
            if (rData !== 8'(c) || rEmpty !== 1'b0 || wFull !== 1'b0) begin
                failures++;
                $display("FAIL stream[%0d]: rData=%h rEmpty=%b wFull=%b, need %h 0 0", c, rData, rEmpty, wFull, 8'(c));
            end
        end
        winc = 1'b0;
        drain(8'd40, 4);
    endtask

    task automatic test_back_to_back();
        // Both requests on empty: only the write lands, rData holds 0x2B
        winc = 1'b1; rinc = 1'b1; wData = 8'h77;
        @(posedge wclk); #1;
        winc = 1'b0;
        checks++;
        if (rEmpty !== 1'b0 || wFull !== 1'b0 || rData !== 8'h2B) begin
            failures++;
            $display("FAIL b2b_empty: rEmpty=%b wFull=%b rData=%h, need 0 0 2b", rEmpty, wFull, rData);
        end
        @(posedge wclk); #1;
        rinc = 1'b0;
        checks++;
        if (rData !== 8'h77 || rEmpty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty_read: rData=%h rEmpty=%b, need 77 1", rData, rEmpty);
        end
        // Both requests on full: only the read lands
        fill16(8'h80);
        winc = 1'b1; rinc = 1'b1; wData = 8'hEE;
        @(posedge wclk); #1;
        winc = 1'b0; rinc = 1'b0;
        checks++;
        if (rData !== 8'h80 || wFull !== 1'b0 || rEmpty !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full: rData=%h wFull=%b rEmpty=%b, need 80 0 0", rData, wFull, rEmpty);
        end
`ifdef ASYNC_FIFO_ERR_EN
        checks++;
        if (wOvf !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full_ovf: wOvf=%b, need 1", wOvf);
        end
`endif
        drain(8'h81, 15);
    endtask

    task automatic test_mid_reset();
        winc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wData = 8'hC0 + 8'(i);
            @(posedge wclk); #1;
        end
        winc = 1'b0;
        #2 wrst = 1'b1;
        #1;
        checks++;
        if (rEmpty !== 1'b1 || wFull !== 1'b0 || rData !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: rEmpty=%b wFull=%b rData=%h, need 1 0 00", rEmpty, wFull, rData);
        end
        #2 wrst = 1'b0;
        winc = 1'b1; wData = 8'h55;
        @(posedge wclk); #1;
        winc = 1'b0; rinc = 1'b1;
        checks++;
        if (rEmpty !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_write: rEmpty=%b, need 0", rEmpty);
        end
        @(posedge wclk); #1;
        rinc = 1'b0;
        checks++;
        if (rData !== 8'h55 || rEmpty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_read: rData=%h rEmpty=%b, need 55 1", rData, rEmpty);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_stream_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock FIFO buffer, depth 2**ADDR_WIDTH, with a write side (winc/wData/wFull) and a read side (rinc/rData/rEmpty).
- Pointers are kept in binary and mirrored in Gray code, so the block can later be split into a dual-clock version without changing its interface semantics.
- Sits between a producer and a consumer in the same clock domain as a rate-smoothing buffer.

Parameters:
- DATA_WIDTH, 8, width of wData/rData in bits.
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH = 16 entries.

Ports:
- wclk  input  1  sole clock; all state updates on the rising edge.
- wrst  input  1  reset, asynchronous, active-high; one clock, no rclk port.
- winc  input  1  write request; accepted on a rising edge when winc=1 and wFull=0.
- wData  input  DATA_WIDTH  write data, captured on an accepted write.
- wFull  output  1  FIFO holds 2**ADDR_WIDTH entries.
- rinc  input  1  read request; accepted on a rising edge when rinc=1 and rEmpty=0.
- rData  output  DATA_WIDTH  read data, registered.
- rEmpty  output  1  FIFO holds 0 entries.

Behaviour:
- Reset (wrst=1, asynchronous): write and read pointers clear to 0 (binary and Gray); wFull=0; rEmpty=1; rData=0. Memory contents are not cleared.
- Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
- Gray value = bin ^ (bin>>1), registered alongside the binary pointer.
- Accepted write: mem[wptr[ADDR_WIDTH-1:0]] <= wData; wptr <= wptr+1.
- Accepted read: rData <= mem[rptr[ADDR_WIDTH-1:0]]; rptr <= rptr+1. rData is valid the cycle after the accepting edge and holds its value until the next accepted read.
- A rejected request (write while full, read while empty) changes no state and no memory; rData holds.
- Flags are registered and computed from next-state Gray pointers, so they are exact in the cycle after the edge:
  - rEmpty = (rgray_next == wgray_next).
  - wFull = (wgray_next == {~rgray_next[A:A-1], rgray_next[A-2:0]}), where A = ADDR_WIDTH.
- Simultaneous winc and rinc:
  - Neither flag set: both are accepted, occupancy is unchanged, and the read returns the oldest entry (never the word written that cycle, unless the FIFO was empty).
  - When full: only the read is accepted, and wFull deasserts the next cycle.
  - When empty: only the write is accepted, and rEmpty deasserts the next cycle; the written word is readable from the following cycle.
- Wrap-around: pointers roll over modulo 2**(ADDR_WIDTH+1). Ordering is preserved across any number of wraps.
- Reset mid-operation: all entries are discarded immediately; the FIFO reads as empty from the reset assertion onward.

Optional Feature:
- Macro: ASYNC_FIFO_ERR_EN.
- Defined: adds two outputs, wOvf (1 bit) and rUdf (1 bit), both registered and reset to 0.
  - wOvf pulses high for one cycle after an edge where winc=1 and wFull=1.
  - rUdf pulses high for one cycle after an edge where rinc=1 and rEmpty=1.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: assert wrst at t=0, release after 10 ns → rEmpty=1, wFull=0, rData=0; no change with winc=rinc=0.
- Fill and drain: write 0x00..0x0F (16 writes) → wFull=1 after the 16th edge. Then read 16 times → rData sequence 0x00..0x0F, one cycle after each accepted read; rEmpty=1 after the 16th read.
- Overflow attempt: when full, winc=1 with wData=0xAA → rejected, wFull stays 1; drain returns 0x00..0x0F with no 0xAA. With ASYNC_FIFO_ERR_EN, wOvf=1 for one cycle.
- Underflow attempt: when empty, rinc=1 → rData holds its last value, rEmpty stays 1. With ASYNC_FIFO_ERR_EN, rUdf=1 for one cycle.
- Concurrent streaming with wrap: preload 4 entries, then run winc=rinc=1 for 40 cycles with an incrementing pattern → output matches input order across 2+ wraps; neither flag asserts.
- Mid-operation reset: write 5 entries, pulse wrst for 3 ns between edges → rEmpty=1 and wFull=0 immediately; a following write of 0x55 then a read returns 0x55.
